// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache AXI master bridge.
// Contents: AXI channel field widths, AXI encodings used by the bridge
// (INCR burst, word-sized transfer, OKAY response), the default line size
// and the bridge state enumeration.
package cache_axi_pkg;

   localparam int AXI_ID_BITS    = 4;
   localparam int AXI_ADDR_BITS  = 32;
   localparam int AXI_DATA_BITS  = 32;
   localparam int AXI_STRB_BITS  = 4;
   localparam int AXI_LEN_BITS   = 4;
   localparam int AXI_SIZE_BITS  = 3;
   localparam int AXI_BURST_BITS = 2;
   localparam int AXI_RESP_BITS  = 2;

   localparam int LINE_WORDS_DEF = 4;

   localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
   localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
   localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW_W,
      ST_B
   } state_t;

endpackage

// File: rtl/cache_line_assembler.sv
// Collects the beats of a line-fill read burst into one cache line.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clear        restarts the beat counter and error accumulator (AR handshake)
//   beat_valid   an R beat is being accepted this cycle
//   beat_data    RDATA of that beat
//   beat_resp    RRESP of that beat
//   beat_last    RLAST of that beat
//   beat_end     combinational: this beat finishes the burst
//   line_done    one-cycle pulse the cycle after the finishing beat
//   line_err     pulse with line_done when any beat erred or the burst was short
//   line         assembled line, word i at bits [32i+31:32i]
module cache_line_assembler
   import cache_axi_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     beat_valid,
   input  logic [AXI_DATA_BITS-1:0] beat_data,
   input  logic [AXI_RESP_BITS-1:0] beat_resp,
   input  logic                     beat_last,
   output logic                     beat_end,
   output logic                     line_done,
   output logic                     line_err,
   output logic [32*LINE_WORDS-1:0] line
);

   localparam int CNT_BITS = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(LINE_WORDS - 1);

   logic [CNT_BITS-1:0] beat_cnt;
   logic                err_acc;
   logic                at_last;
   logic                beat_bad;
   logic                early_last;

   // The burst ends on RLAST or when the final word slot is filled, whichever
   // comes first; an RLAST before the final slot means a short burst.
   assign at_last    = (beat_cnt == LAST_IDX);
   assign beat_end   = beat_valid && (beat_last || at_last);
   assign beat_bad   = (beat_resp != RESP_OKAY);
   assign early_last = beat_last && !at_last;

   // Word slots not reached by a short burst keep their old contents. The
   // counter stops at the final slot instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         err_acc   <= 1'b0;
         line      <= '0;
         line_done <= 1'b0;
         line_err  <= 1'b0;
      end else begin
         line_done <= beat_end;
         line_err  <= beat_end && (err_acc || beat_bad || early_last);
         if (clear) begin
            beat_cnt <= '0;
            err_acc  <= 1'b0;
         end else if (beat_valid) begin
            line[32*int'(beat_cnt) +: 32] <= beat_data;
            err_acc <= err_acc || beat_bad;
            if (!beat_end) begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cache_axi_master.sv
// AXI4 master bridge between the L1 cache controllers and the bus.
// A miss becomes a LINE_WORDS-beat INCR read whose data is returned as one
// line with fill_valid; a write-through store becomes a single-beat write
// acknowledged with wr_done. One transaction is outstanding at a time.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_*                          cache request (valid/ready, write, addr, wdata, wstrb)
//   fill_valid, fill_line          completed line fill
//   wr_done                        completed write
//   bus_err                        pulses with fill_valid/wr_done on a non-OKAY response
//   AW*/W*/B*/AR*/R*               AXI4 master channels
module cache_axi_master
   import cache_axi_pkg::*;
#(
   parameter logic [AXI_ID_BITS-1:0] MASTER_ID  = 4'd0,
   parameter int                     LINE_WORDS = LINE_WORDS_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wdata,
   input  logic [3:0]                req_wstrb,
   output logic                      fill_valid,
   output logic [32*LINE_WORDS-1:0]  fill_line,
   output logic                      wr_done,
   output logic                      bus_err,
   output logic [AXI_ID_BITS-1:0]    AWID,
   output logic [AXI_ADDR_BITS-1:0]  AWADDR,
   output logic [AXI_LEN_BITS-1:0]   AWLEN,
   output logic [AXI_SIZE_BITS-1:0]  AWSIZE,
   output logic [AXI_BURST_BITS-1:0] AWBURST,
   output logic                      AWVALID,
   input  logic                      AWREADY,
   output logic [AXI_DATA_BITS-1:0]  WDATA,
   output logic [AXI_STRB_BITS-1:0]  WSTRB,
   output logic                      WLAST,
   output logic                      WVALID,
   input  logic                      WREADY,
   input  logic [AXI_ID_BITS-1:0]    BID,
   input  logic [AXI_RESP_BITS-1:0]  BRESP,
   input  logic                      BVALID,
   output logic                      BREADY,
   output logic [AXI_ID_BITS-1:0]    ARID,
   output logic [AXI_ADDR_BITS-1:0]  ARADDR,
   output logic [AXI_LEN_BITS-1:0]   ARLEN,
   output logic [AXI_SIZE_BITS-1:0]  ARSIZE,
   output logic [AXI_BURST_BITS-1:0] ARBURST,
   output logic                      ARVALID,
   input  logic                      ARREADY,
   input  logic [AXI_ID_BITS-1:0]    RID,
   input  logic [AXI_DATA_BITS-1:0]  RDATA,
   input  logic [AXI_RESP_BITS-1:0]  RRESP,
   input  logic                      RLAST,
   input  logic                      RVALID,
   output logic                      RREADY
);

   state_t      state;
   state_t      next_state;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        write_q;
   logic        aw_done;
   logic        w_done;
   logic        aw_hs;
   logic        w_hs;
   logic        accept;
   logic        wr_done_q;
   logic        b_err_q;
   logic        fill_err;
   logic        beat_end;

   // Response IDs are not checked: only one transaction is ever in flight.
   logic unused_ids;
   assign unused_ids = ^{BID, RID};

   // Address/data channel fields come straight from the latched request so
   // they stay stable for as long as the matching VALID is high.
   assign ARID    = MASTER_ID;
   assign ARADDR  = {addr_q[31:4], 4'b0000};
   assign ARLEN   = AXI_LEN_BITS'(LINE_WORDS - 1);
   assign ARSIZE  = SIZE_WORD;
   assign ARBURST = BURST_INCR;
   assign AWID    = MASTER_ID;
   assign AWADDR  = addr_q;
   assign AWLEN   = '0;
   assign AWSIZE  = SIZE_WORD;
   assign AWBURST = BURST_INCR;
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;
   assign WLAST   = 1'b1;

   assign wr_done = wr_done_q;
   assign bus_err = fill_err || b_err_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and channel handshake signals. VALIDs and READYs depend only
   // on registered state, never on the opposite side's READY/VALID. The
   // request port stays closed during the completion pulse cycle so a new
   // request lands no earlier than the cycle after it.
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      ARVALID    = 1'b0;
      RREADY     = 1'b0;
      AWVALID    = 1'b0;
      WVALID     = 1'b0;
      BREADY     = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = !fill_valid && !wr_done_q;
            if (req_valid && req_ready) begin
               next_state = req_write ? ST_AW_W : ST_AR;
            end
         end
         ST_AR: begin
            ARVALID = 1'b1;
            if (ARREADY) begin
               next_state = ST_R;
            end
         end
         ST_R: begin
            RREADY = 1'b1;
            if (beat_end) begin
               next_state = ST_IDLE;
            end
         end
         ST_AW_W: begin
            AWVALID = !aw_done;
            WVALID  = !w_done;
            if ((aw_done || (AWVALID && AWREADY)) && (w_done || (WVALID && WREADY))) begin
               next_state = ST_B;
            end
         end
         ST_B: begin
            BREADY = 1'b1;
            if (BVALID) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign accept = (state == ST_IDLE) && req_valid && req_ready;
   assign aw_hs  = (state == ST_AW_W) && !aw_done && AWREADY;
   assign w_hs   = (state == ST_AW_W) && !w_done && WREADY;

   // Request latch plus the independent AW/W completion flags; the flags are
   // cleared whenever a new request is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         write_q <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            write_q <= req_write;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
         end
      end
   end

   // Write response: completion and error pulses land one cycle after the
   // B handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_done_q <= 1'b0;
         b_err_q   <= 1'b0;
      end else begin
         wr_done_q <= (state == ST_B) && BVALID;
         b_err_q   <= (state == ST_B) && BVALID && (BRESP != RESP_OKAY);
      end
   end

   // The latched write flag is kept for visibility of the request in
   // progress; the FSM already encodes the transaction kind.
   logic unused_write;
   assign unused_write = write_q;

   cache_line_assembler #(
      .LINE_WORDS (LINE_WORDS)
   ) u_assembler (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      ((state == ST_AR) && ARREADY),
      .beat_valid ((state == ST_R) && RVALID),
      .beat_data  (RDATA),
      .beat_resp  (RRESP),
      .beat_last  (RLAST),
      .beat_end   (beat_end),
      .line_done  (fill_valid),
      .line_err   (fill_err),
      .line       (fill_line)
   );

endmodule

// File: tb/tb_cache_axi_master.sv
// Directed testbench for cache_axi_master: the bench plays both the cache
// and the AXI slave, and compares every observed output with hand-computed
// values.
module tb_cache_axi_master;
   import cache_axi_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [31:0]  req_addr;
   logic [31:0]  req_wdata;
   logic [3:0]   req_wstrb;
   logic         fill_valid;
   logic [127:0] fill_line;
   logic         wr_done;
   logic         bus_err;
   logic [3:0]   AWID;
   logic [31:0]  AWADDR;
   logic [3:0]   AWLEN;
   logic [2:0]   AWSIZE;
   logic [1:0]   AWBURST;
   logic         AWVALID;
   logic         AWREADY;
   logic [31:0]  WDATA;
   logic [3:0]   WSTRB;
   logic         WLAST;
   logic         WVALID;
   logic         WREADY;
   logic [3:0]   BID;
   logic [1:0]   BRESP;
   logic         BVALID;
   logic         BREADY;
   logic [3:0]   ARID;
   logic [31:0]  ARADDR;
   logic [3:0]   ARLEN;
   logic [2:0]   ARSIZE;
   logic [1:0]   ARBURST;
   logic         ARVALID;
   logic         ARREADY;
   logic [3:0]   RID;
   logic [31:0]  RDATA;
   logic [1:0]   RRESP;
   logic         RLAST;
   logic         RVALID;
   logic         RREADY;

   int checkCount = 0;
   int passCount  = 0;

   cache_axi_master dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .fill_valid(fill_valid), .fill_line(fill_line), .wr_done(wr_done), .bus_err(bus_err),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   // 10 ns clock; inputs change on the falling edge, outputs are sampled there.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the design wedges somewhere the bounded waits miss.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got still running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one cache request for a single cycle.
   task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s);
      @(negedge clk);
      checkOutput("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // Offer one R beat and hold it until RREADY is seen at a rising edge.
   task automatic rBeat(input logic [31:0] d, input logic [1:0] resp, input logic last);
      bit got = 1'b0;
      @(negedge clk);
      RVALID = 1'b1;
      RDATA  = d;
      RRESP  = resp;
      RLAST  = last;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         if (RREADY) got = 1'b1;
      end
      #1;
      RVALID = 1'b0;
      RLAST  = 1'b0;
      if (!got) checkOutput("r_timeout", 1'b0, 1'b1);
   endtask

   // Offer a write response and hold it until BREADY is seen.
   task automatic bResp(input logic [1:0] resp);
      bit got = 1'b0;
      @(negedge clk);
      BVALID = 1'b1;
      BRESP  = resp;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         if (BREADY) got = 1'b1;
      end
      #1 BVALID = 1'b0;
      if (!got) checkOutput("b_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      AWREADY = 1'b0; WREADY = 1'b0;
      BID = 4'h5; BRESP = 2'b00; BVALID = 1'b0;
      ARREADY = 1'b1;
      RID = 4'h3; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk);
      checkOutput("rst_arvalid", ARVALID, 1'b0);
      checkOutput("rst_awvalid", AWVALID, 1'b0);
      checkOutput("rst_wvalid", WVALID, 1'b0);
      checkOutput("rst_rready", RREADY, 1'b0);
      checkOutput("rst_bready", BREADY, 1'b0);
      checkOutput("rst_fill_valid", fill_valid, 1'b0);
      checkOutput("rst_wr_done", wr_done, 1'b0);
      checkOutput("rst_bus_err", bus_err, 1'b0);
      checkOutput("rst_fill_line", fill_line, 128'h0);
      rst_n = 1'b1;

      // Line fill, slave always ready.
      applyStimulus(1'b0, 32'h0000_1234, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("t1_arvalid", ARVALID, 1'b1);
      checkOutput("t1_araddr", ARADDR, 32'h0000_1230);
      checkOutput("t1_arlen", ARLEN, 4'd3);
      checkOutput("t1_arsize", ARSIZE, 3'b010);
      checkOutput("t1_arburst", ARBURST, 2'b01);
      checkOutput("t1_arid", ARID, 4'd0);
      checkOutput("t1_req_ready_busy", req_ready, 1'b0);
      rBeat(32'hA0, 2'b00, 1'b0);
      rBeat(32'hA1, 2'b00, 1'b0);
      rBeat(32'hA2, 2'b00, 1'b0);
      rBeat(32'hA3, 2'b00, 1'b1);
      @(negedge clk);
      checkOutput("t1_fill_valid", fill_valid, 1'b1);
      checkOutput("t1_fill_line", fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      checkOutput("t1_bus_err", bus_err, 1'b0);
      checkOutput("t1_req_ready_pulse", req_ready, 1'b0);
      @(negedge clk);
      checkOutput("t1_fill_valid_drop", fill_valid, 1'b0);
      checkOutput("t1_req_ready_after", req_ready, 1'b1);

      // Line fill with a slow AR slave and gaps between R beats.
      ARREADY = 1'b0;
      applyStimulus(1'b0, 32'h0000_5678, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t2_arvalid_hold", ARVALID, 1'b1);
         checkOutput("t2_araddr_hold", ARADDR, 32'h0000_5670);
         checkOutput("t2_req_ready", req_ready, 1'b0);
      end
      ARREADY = 1'b1;
      @(posedge clk);
      #1 ARREADY = 1'b0;
      rBeat(32'hB0, 2'b00, 1'b0);
      @(negedge clk);
      checkOutput("t2_rready_gap", RREADY, 1'b1);
      checkOutput("t2_no_early_fill", fill_valid, 1'b0);
      rBeat(32'hB1, 2'b00, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("t2_req_ready_gap", req_ready, 1'b0);
      rBeat(32'hB2, 2'b00, 1'b0);
      rBeat(32'hB3, 2'b00, 1'b1);
      @(negedge clk);
      checkOutput("t2_fill_valid", fill_valid, 1'b1);
      checkOutput("t2_fill_line", fill_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
      checkOutput("t2_bus_err", bus_err, 1'b0);
      ARREADY = 1'b1;

      // Write where W handshakes first and AW follows a few cycles later.
      WREADY  = 1'b1;
      AWREADY = 1'b0;
      applyStimulus(1'b1, 32'h2000_0008, 32'hDEAD_BEEF, 4'b0011);
      @(negedge clk);
      checkOutput("t3_awvalid", AWVALID, 1'b1);
      checkOutput("t3_wvalid", WVALID, 1'b1);
      checkOutput("t3_awaddr", AWADDR, 32'h2000_0008);
      checkOutput("t3_awlen", AWLEN, 4'd0);
      checkOutput("t3_awsize", AWSIZE, 3'b010);
      checkOutput("t3_awburst", AWBURST, 2'b01);
      checkOutput("t3_awid", AWID, 4'd0);
      checkOutput("t3_wdata", WDATA, 32'hDEAD_BEEF);
      checkOutput("t3_wstrb", WSTRB, 4'b0011);
      checkOutput("t3_wlast", WLAST, 1'b1);
      @(negedge clk);
      checkOutput("t3_wvalid_drop", WVALID, 1'b0);
      checkOutput("t3_awvalid_hold1", AWVALID, 1'b1);
      @(negedge clk);
      checkOutput("t3_awvalid_hold2", AWVALID, 1'b1);
      checkOutput("t3_bready_early", BREADY, 1'b0);
      @(negedge clk);
      checkOutput("t3_awaddr_hold", AWADDR, 32'h2000_0008);
      AWREADY = 1'b1;
      @(posedge clk);
      #1 AWREADY = 1'b0;
      @(negedge clk);
      checkOutput("t3_awvalid_drop", AWVALID, 1'b0);
      checkOutput("t3_bready", BREADY, 1'b1);
      checkOutput("t3_wr_done_early", wr_done, 1'b0);
      bResp(2'b00);
      @(negedge clk);
      checkOutput("t3_wr_done", wr_done, 1'b1);
      checkOutput("t3_bus_err", bus_err, 1'b0);
      checkOutput("t3_req_ready_pulse", req_ready, 1'b0);
      @(negedge clk);
      checkOutput("t3_wr_done_drop", wr_done, 1'b0);

      // Write with AW and W in the same cycle, SLVERR response.
      AWREADY = 1'b1;
      WREADY  = 1'b1;
      applyStimulus(1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF);
      @(negedge clk);
      checkOutput("t4_awvalid", AWVALID, 1'b1);
      checkOutput("t4_wvalid", WVALID, 1'b1);
      @(negedge clk);
      checkOutput("t4_awvalid_drop", AWVALID, 1'b0);
      checkOutput("t4_wvalid_drop", WVALID, 1'b0);
      checkOutput("t4_bready", BREADY, 1'b1);
      bResp(2'b10);
      @(negedge clk);
      checkOutput("t4_wr_done", wr_done, 1'b1);
      checkOutput("t4_bus_err", bus_err, 1'b1);
      @(negedge clk);
      checkOutput("t4_wr_done_single", wr_done, 1'b0);
      checkOutput("t4_bus_err_drop", bus_err, 1'b0);

      // Short burst: RLAST on the second beat leaves words 2-3 untouched.
      applyStimulus(1'b0, 32'h0000_1230, 32'h0, 4'h0);
      rBeat(32'hC0, 2'b00, 1'b0);
      rBeat(32'hC1, 2'b00, 1'b1);
      @(negedge clk);
      checkOutput("t5_fill_valid", fill_valid, 1'b1);
      checkOutput("t5_fill_line", fill_line, {32'hB3, 32'hB2, 32'hC1, 32'hC0});
      checkOutput("t5_bus_err", bus_err, 1'b1);
      @(negedge clk);
      checkOutput("t5_fill_valid_drop", fill_valid, 1'b0);
      checkOutput("t5_arvalid_idle", ARVALID, 1'b0);

      // Reset in the middle of a burst, then a clean fill.
      applyStimulus(1'b0, 32'h0000_4440, 32'h0, 4'h0);
      rBeat(32'hD0, 2'b00, 1'b0);
      rBeat(32'hD1, 2'b00, 1'b0);
      @(negedge clk);
      RVALID = 1'b1;
      RDATA  = 32'hD2;
      rst_n  = 1'b0;
      #1;
      checkOutput("t6_rst_fill_line", fill_line, 128'h0);
      checkOutput("t6_rst_rready", RREADY, 1'b0);
      checkOutput("t6_rst_fill_valid", fill_valid, 1'b0);
      checkOutput("t6_rst_bus_err", bus_err, 1'b0);
      RVALID = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t6_no_fill_after_rst", fill_valid, 1'b0);
         checkOutput("t6_idle_arvalid", ARVALID, 1'b0);
      end
      applyStimulus(1'b0, 32'h0000_4440, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("t6_araddr", ARADDR, 32'h0000_4440);
      rBeat(32'hE0, 2'b00, 1'b0);
      rBeat(32'hE1, 2'b00, 1'b0);
      rBeat(32'hE2, 2'b00, 1'b0);
      rBeat(32'hE3, 2'b00, 1'b1);
      @(negedge clk);
      checkOutput("t6_fill_valid", fill_valid, 1'b1);
      checkOutput("t6_fill_line", fill_line, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
      checkOutput("t6_bus_err", bus_err, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
